// File: rtl/conv_sequencer.sv
// conv_sequencer
// Generates the 34-bit core instruction word for one full 3x3 convolution
// pass. For each kernel position (kij) it runs these phases in order:
// weight fetch into L0, array load, pipeline drain wait, activation fetch,
// execute, and ofifo drain into pmem. The drain accumulates from kij 1 onward.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low (0 = reset)
//   start      begin a pass; only looked at while idle
//   valid      core ofifo holds a complete output row
//   inst[33:0] registered core instruction word; lags the state by one cycle
//   busy       high in every state except IDLE
//   done       one-cycle pulse while the FSM sits in DONE
//   kij_idx    current kernel position
//   state_dbg  current FSM state encoding, for observation only
//
// Handshakes: the host raises start while busy is low; the pass is accepted
// on that edge, and start is ignored until busy falls again. done marks the
// end of the pass. On the core side a row is taken by registering ofifo_rd on
// an edge where valid is high. At most one read is issued per two cycles, so
// valid is always re-evaluated after the previous pop.
module conv_sequencer #(
  parameter int COL        = 8,
  parameter int LEN_KIJ    = 9,
  parameter int LEN_NIJ    = 36,
  parameter int X_BASE     = 0,
  parameter int W_BASE     = 36,
  parameter int P_BASE     = 0,
  parameter int LOAD_DRAIN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_idx,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_FETCH, S_W_LOAD, S_W_WAIT, S_X_FETCH, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic        acc;
    logic        cen_pmem;
    logic        wen_pmem;
    logic [10:0] a_pmem;
    logic        cen_xmem;
    logic        wen_xmem;
    logic [10:0] a_xmem;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        execute;
    logic        load;
  } inst_t;

  localparam inst_t       IDLE_INST = inst_t'(34'h1800C0000);
  localparam logic [7:0]  COL_C     = 8'(COL);
  localparam logic [7:0]  NIJ_C     = 8'(LEN_NIJ);
  localparam logic [7:0]  WAIT_C    = 8'(LOAD_DRAIN);
  localparam logic [3:0]  LAST_KIJ  = 4'(LEN_KIJ - 1);
  localparam logic [10:0] COL_A     = 11'(COL);
  localparam logic [10:0] X_BASE_A  = 11'(X_BASE);
  localparam logic [10:0] W_BASE_A  = 11'(W_BASE);
  localparam logic [10:0] P_BASE_A  = 11'(P_BASE);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic [3:0] kij_q, kij_d;
  inst_t      inst_q, inst_d;
  logic       busy_q, done_q;

  always_comb begin
    state_d  = state_q;
    kij_d    = kij_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    inst_d   = IDLE_INST;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_W_FETCH;
          kij_d   = '0;
        end
      end

      // One extra cycle so the last SRAM read (one-cycle latency) lands in L0.
      S_W_FETCH: begin
        if (cnt_q < COL_C) begin
          inst_d.cen_xmem = 1'b0;
          inst_d.a_xmem   = W_BASE_A + 11'(kij_q) * COL_A + 11'(cnt_q);
        end
        if (cnt_q != 8'd0) inst_d.l0_wr = 1'b1;
        if (cnt_q == COL_C) state_d = S_W_LOAD;
      end

      S_W_LOAD: begin
        inst_d.l0_rd = 1'b1;
        inst_d.load  = 1'b1;
        if (cnt_q == COL_C - 8'd1) state_d = S_W_WAIT;
      end

      S_W_WAIT: begin
        if (cnt_q == WAIT_C - 8'd1) state_d = S_X_FETCH;
      end

      S_X_FETCH: begin
        if (cnt_q < NIJ_C) begin
          inst_d.cen_xmem = 1'b0;
          inst_d.a_xmem   = X_BASE_A + 11'(cnt_q);
        end
        if (cnt_q != 8'd0) inst_d.l0_wr = 1'b1;
        if (cnt_q == NIJ_C) state_d = S_EXEC;
      end

      S_EXEC: begin
        inst_d.l0_rd   = 1'b1;
        inst_d.execute = 1'b1;
        if (cnt_q == NIJ_C - 8'd1) state_d = S_DRAIN;
      end

      // A read in the current word always becomes a pmem write in the next
      // one, so reads and writes alternate. The pass moves on on the
      // same edge that registers the last write.
      S_DRAIN: begin
        if (inst_q.ofifo_rd) begin
          inst_d.cen_pmem = 1'b0;
          inst_d.wen_pmem = 1'b0;
          inst_d.a_pmem   = P_BASE_A + 11'(wr_cnt_q);
          inst_d.acc      = (kij_q != 4'd0);
          wr_cnt_d        = wr_cnt_q + 8'd1;
          if (wr_cnt_q == NIJ_C - 8'd1) begin
            if (kij_q == LAST_KIJ) begin
              state_d = S_DONE;
            end else begin
              kij_d   = kij_q + 4'd1;
              state_d = S_W_FETCH;
            end
          end
        end else if (valid && (rd_cnt_q < NIJ_C)) begin
          inst_d.ofifo_rd = 1'b1;
          rd_cnt_d        = rd_cnt_q + 8'd1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Every state change starts the per-state counters from zero.
    if (state_d != state_q) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end
    cnt_d = ((state_d != state_q) || (state_q == S_IDLE)) ? 8'd0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      kij_q    <= '0;
      inst_q   <= IDLE_INST;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      kij_q    <= kij_d;
      inst_q   <= inst_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign inst      = inst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign kij_idx   = kij_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: directed phase checks plus a randomized-valid
// full pass compared against an address/event model of the pass.
module tb_conv_sequencer;

  localparam int COL        = 8;
  localparam int LEN_KIJ    = 9;
  localparam int LEN_NIJ    = 36;
  localparam int X_BASE     = 0;
  localparam int W_BASE     = 36;
  localparam int P_BASE     = 0;
  localparam int LOAD_DRAIN = 16;
  localparam int KIJ_CYC    = (COL + 1) + COL + LOAD_DRAIN + (LEN_NIJ + 1) + LEN_NIJ + 2 * LEN_NIJ;
  localparam int EXEC_OFS   = (COL + 1) + COL + LOAD_DRAIN + (LEN_NIJ + 1);
  localparam int DRAIN_OFS  = EXEC_OFS + LEN_NIJ;
  localparam logic [33:0] IDLE_WORD = 34'h1800C0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;
  logic [2:0]  state_dbg;

  conv_sequencer #(
    .COL(COL), .LEN_KIJ(LEN_KIJ), .LEN_NIJ(LEN_NIJ), .X_BASE(X_BASE),
    .W_BASE(W_BASE), .P_BASE(P_BASE), .LOAD_DRAIN(LOAD_DRAIN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .valid(valid),
    .inst(inst), .busy(busy), .done(done), .kij_idx(kij_idx),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic valid_at_edge = 1'b0;
  always @(posedge clk) valid_at_edge <= valid;

  int n_cmp = 0;
  int n_err = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- monitor / scoreboard logs ----------------
  logic        mon_en = 1'b0;
  logic        prev_rd = 1'b0;
  logic [10:0] xrd_q[$];
  logic [11:0] pw_q[$];
  int          done_cyc_q[$];
  int          rd_back2back = 0;
  int          orphan_wr = 0;
  int          rd_while_invalid = 0;
  logic [10:0] exp_x_q[$];
  logic [11:0] exp_p_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (inst[19] == 1'b0) xrd_q.push_back(inst[17:7]);
      if (inst[32] == 1'b0 && inst[31] == 1'b0) begin
        pw_q.push_back({inst[33], inst[30:20]});
        if (!prev_rd) orphan_wr++;
      end
      if (inst[6]) begin
        if (prev_rd) rd_back2back++;
        if (!valid_at_edge) rd_while_invalid++;
      end
      if (done) done_cyc_q.push_back(cyc);
      prev_rd = inst[6];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    mon_en = 1'b0;
    xrd_q.delete();
    pw_q.delete();
    done_cyc_q.delete();
    rd_back2back = 0;
    orphan_wr = 0;
    rd_while_invalid = 0;
    prev_rd = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse_start(output int c0);
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Runs one pass from start until done (or budget), counting busy-low cycles.
  task automatic run_pass(input bit rand_valid, input int budget, output int c0,
                          output bit got_done, output int done_at, output int busy_low);
    busy_low = 0;
    got_done = 1'b0;
    done_at  = -1;
    valid    = 1'b1;
    pulse_start(c0);
    for (int i = 0; i < budget; i++) begin
      if (!busy) busy_low++;
      if (done) begin
        got_done = 1'b1;
        done_at  = cyc;
        break;
      end
      if (rand_valid) valid = ($urandom_range(0, 99) < 60);
      @(negedge clk);
    end
  endtask

  // Expected word on inst cycle k of kij 0: fetch, load, then idle wait.
  function automatic logic [33:0] front_word(input int k);
    logic [33:0] w;
    w = IDLE_WORD;
    if (k < COL) begin
      w[19]   = 1'b0;
      w[17:7] = 11'(W_BASE + k);
    end
    if (k >= 1 && k <= COL) w[2] = 1'b1;
    if (k > COL && k <= 2 * COL) begin
      w[3] = 1'b1;
      w[0] = 1'b1;
    end
    return w;
  endfunction

  task automatic build_expected();
    exp_x_q.delete();
    exp_p_q.delete();
    for (int k = 0; k < LEN_KIJ; k++) begin
      for (int i = 0; i < COL; i++) exp_x_q.push_back(11'(W_BASE + k * COL + i));
      for (int i = 0; i < LEN_NIJ; i++) exp_x_q.push_back(11'(X_BASE + i));
      for (int i = 0; i < LEN_NIJ; i++) exp_p_q.push_back({(k != 0), 11'(P_BASE + i)});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int changes;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (inst !== IDLE_WORD) begin n_err++; $display("FAIL reset_inst got=%h exp=%h", inst, IDLE_WORD); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (kij_idx !== 4'd0) begin n_err++; $display("FAIL reset_kij got=%0d exp=0", kij_idx); end
    changes = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (inst !== IDLE_WORD || busy !== 1'b0 || done !== 1'b0) changes++;
    end
    n_cmp++; if (changes != 0) begin n_err++; $display("FAIL idle_hold changed_cycles=%0d exp=0", changes); end
  endtask

  task automatic test_weight_fetch();
    int c0;
    logic [33:0] exp_w;
    clear_logs();
    valid = 1'b1;
    pulse_start(c0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wf_busy_rise got=%b exp=1", busy); end
    n_cmp++; if (inst !== IDLE_WORD) begin n_err++; $display("FAIL wf_lag got=%h exp=%h", inst, IDLE_WORD); end
    for (int k = 0; k < (COL + 1) + COL + LOAD_DRAIN; k++) begin
      @(negedge clk);
      exp_w = front_word(k);
      n_cmp++;
      if (inst !== exp_w) begin
        n_err++;
        $display("FAIL wf_word k=%0d got=%h exp=%h", k, inst, exp_w);
      end
    end
    n_cmp++; if (kij_idx !== 4'd0) begin n_err++; $display("FAIL wf_kij got=%0d exp=0", kij_idx); end
    apply_reset(2);
  endtask

  task automatic test_full_pass();
    int c0, done_at, busy_low, base, bad;
    bit got_done;
    logic [11:0] e;
    clear_logs();
    mon_en = 1'b1;
    run_pass(1'b0, 4000, c0, got_done, done_at, busy_low);
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    n_cmp++; if (!got_done) begin n_err++; $display("FAIL full_done_seen got=0 exp=1"); end
    n_cmp++; if (done_at != c0 + 1 + LEN_KIJ * KIJ_CYC) begin
      n_err++; $display("FAIL full_done_time got=%0d exp=%0d", done_at - c0 - 1, LEN_KIJ * KIJ_CYC); end
    n_cmp++; if (done_cyc_q.size() != 1) begin n_err++; $display("FAIL full_done_pulses got=%0d exp=1", done_cyc_q.size()); end
    n_cmp++; if (busy_low != 0) begin n_err++; $display("FAIL full_busy_low got=%0d exp=0", busy_low); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy_after got=%b exp=0", busy); end
    // kij 8 weight rows
    base = (LEN_KIJ - 1) * (COL + LEN_NIJ);
    bad = 0;
    for (int i = 0; i < COL; i++) begin
      if (base + i >= xrd_q.size()) bad++;
      else if (xrd_q[base + i] !== 11'(W_BASE + (LEN_KIJ - 1) * COL + i)) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL full_kij8_waddr bad=%0d exp=0 (first=%0d)", bad,
      (base < xrd_q.size()) ? int'(xrd_q[base]) : -1); end
    // accumulate flag on kij 0 and kij 1 writes
    bad = 0;
    for (int i = 0; i < 2 * LEN_NIJ; i++) begin
      e = {(i >= LEN_NIJ), 11'(P_BASE + (i % LEN_NIJ))};
      if (i >= pw_q.size()) bad++;
      else if (pw_q[i] !== e) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL full_acc_kij01 bad=%0d exp=0", bad); end
    n_cmp++; if (pw_q.size() != LEN_KIJ * LEN_NIJ) begin
      n_err++; $display("FAIL full_pw_count got=%0d exp=%0d", pw_q.size(), LEN_KIJ * LEN_NIJ); end
    n_cmp++; if (rd_back2back != 0) begin n_err++; $display("FAIL full_rd_b2b got=%0d exp=0", rd_back2back); end
  endtask

  task automatic test_stall();
    int c0, nrd, gap_rd, gap_wr, bad;
    logic [33:0] w;
    clear_logs();
    mon_en = 1'b1;
    valid = 1'b1;
    pulse_start(c0);
    nrd = 0;
    for (int i = 0; i < 2000 && nrd < 5; i++) begin
      @(negedge clk);
      if (inst[6]) nrd++;
    end
    n_cmp++; if (nrd != 5) begin n_err++; $display("FAIL stall_reach_read5 got=%0d exp=5", nrd); end
    valid = 1'b0;
    @(negedge clk);
    w = inst;
    n_cmp++; if (w[32:31] !== 2'b00 || w[30:20] !== 11'(P_BASE + 4)) begin
      n_err++; $display("FAIL stall_pending_write got=%h exp A_pmem=%0d", w, P_BASE + 4); end
    gap_rd = 0;
    gap_wr = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (inst[6]) gap_rd++;
      if (!inst[32]) gap_wr++;
    end
    n_cmp++; if (gap_rd != 0 || gap_wr != 0) begin
      n_err++; $display("FAIL stall_gap reads=%0d writes=%0d exp=0/0", gap_rd, gap_wr); end
    valid = 1'b1;
    w = IDLE_WORD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!inst[32]) begin w = inst; break; end
    end
    n_cmp++; if (w[32] !== 1'b0 || w[30:20] !== 11'(P_BASE + 5)) begin
      n_err++; $display("FAIL stall_resume_addr got=%h exp A_pmem=%0d", w, P_BASE + 5); end
    for (int i = 0; i < 500 && kij_idx != 4'd1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    n_cmp++; if (pw_q.size() != LEN_NIJ) begin n_err++; $display("FAIL stall_write_count got=%0d exp=%0d", pw_q.size(), LEN_NIJ); end
    bad = 0;
    for (int i = 0; i < pw_q.size(); i++)
      if (pw_q[i] !== {1'b0, 11'(P_BASE + i)}) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stall_write_addrs bad=%0d exp=0", bad); end
    n_cmp++; if (rd_while_invalid != 0) begin n_err++; $display("FAIL stall_rd_invalid got=%0d exp=0", rd_while_invalid); end
    apply_reset(2);
  endtask

  task automatic test_random_pass();
    int c0, done_at, busy_low, bad, n;
    bit got_done;
    build_expected();
    clear_logs();
    mon_en = 1'b1;
    run_pass(1'b1, 20000, c0, got_done, done_at, busy_low);
    valid = 1'b1;
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    n_cmp++; if (!got_done) begin n_err++; $display("FAIL rnd_done_seen got=0 exp=1"); end
    n_cmp++; if (done_at < c0 + 1 + LEN_KIJ * KIJ_CYC) begin
      n_err++; $display("FAIL rnd_done_early got=%0d exp>=%0d", done_at - c0 - 1, LEN_KIJ * KIJ_CYC); end
    n_cmp++; if (busy_low != 0) begin n_err++; $display("FAIL rnd_busy_low got=%0d exp=0", busy_low); end
    n_cmp++; if (xrd_q.size() != exp_x_q.size()) begin
      n_err++; $display("FAIL rnd_xmem_count got=%0d exp=%0d", xrd_q.size(), exp_x_q.size()); end
    bad = 0;
    n = (xrd_q.size() < exp_x_q.size()) ? xrd_q.size() : exp_x_q.size();
    for (int i = 0; i < n; i++) if (xrd_q[i] !== exp_x_q[i]) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rnd_xmem_addrs bad=%0d exp=0", bad); end
    n_cmp++; if (pw_q.size() != exp_p_q.size()) begin
      n_err++; $display("FAIL rnd_pmem_count got=%0d exp=%0d", pw_q.size(), exp_p_q.size()); end
    bad = 0;
    n = (pw_q.size() < exp_p_q.size()) ? pw_q.size() : exp_p_q.size();
    for (int i = 0; i < n; i++) if (pw_q[i] !== exp_p_q[i]) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rnd_pmem_writes bad=%0d exp=0", bad); end
    n_cmp++; if (rd_back2back != 0) begin n_err++; $display("FAIL rnd_rd_b2b got=%0d exp=0", rd_back2back); end
    n_cmp++; if (orphan_wr != 0) begin n_err++; $display("FAIL rnd_orphan_write got=%0d exp=0", orphan_wr); end
    n_cmp++; if (rd_while_invalid != 0) begin n_err++; $display("FAIL rnd_rd_invalid got=%0d exp=0", rd_while_invalid); end
    n_cmp++; if (done_cyc_q.size() != 1) begin n_err++; $display("FAIL rnd_done_pulses got=%0d exp=1", done_cyc_q.size()); end
  endtask

  task automatic test_mid_pass();
    int c0, still_idle;
    clear_logs();
    valid = 1'b1;
    pulse_start(c0);
    wait_until(c0 + 1 + 2 * KIJ_CYC + EXEC_OFS + 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (kij_idx !== 4'd2) begin n_err++; $display("FAIL busy_start_kij got=%0d exp=2", kij_idx); end
    n_cmp++; if (inst[1] !== 1'b1) begin n_err++; $display("FAIL busy_start_exec got=%b exp=1", inst[1]); end
    wait_until(c0 + 1 + 3 * KIJ_CYC + DRAIN_OFS + 20);
    n_cmp++; if (kij_idx !== 4'd3) begin n_err++; $display("FAIL drain3_kij got=%0d exp=3", kij_idx); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (inst !== IDLE_WORD) begin n_err++; $display("FAIL async_rst_inst got=%h exp=%h", inst, IDLE_WORD); end
    n_cmp++; if (kij_idx !== 4'd0) begin n_err++; $display("FAIL async_rst_kij got=%0d exp=0", kij_idx); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL async_rst_flags busy=%b done=%b exp=0/0", busy, done); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    still_idle = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (inst === IDLE_WORD && busy === 1'b0) still_idle++;
    end
    n_cmp++; if (still_idle != 5) begin n_err++; $display("FAIL no_auto_restart idle_cycles=%0d exp=5", still_idle); end
    pulse_start(c0);
    @(negedge clk);
    n_cmp++; if (inst[19] !== 1'b0 || inst[17:7] !== 11'(W_BASE)) begin
      n_err++; $display("FAIL restart_addr got CEN=%b A=%0d exp CEN=0 A=%0d", inst[19], inst[17:7], W_BASE); end
    apply_reset(2);
  endtask

  initial begin
    test_reset();
    test_weight_fetch();
    test_full_pass();
    test_stall();
    test_random_pass();
    test_mid_pass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
